// File: rtl/teclado_pkg.sv
// Shared keypad types and defaults for the operand capture slice.
package teclado_pkg;

  localparam int unsigned KP_WIDTH           = 4;
  localparam int unsigned DEFAULT_MAX_DIGITS = 4;

  typedef enum logic [3:0] {
    KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
    KEY_STAR, KEY_HASH, KEY_NONE
  } key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    WAIT_LOW
  } cap_state_t;

endpackage

// File: rtl/captura_operando_if.sv
// Key intake and operand offer signals of captura_operando.
interface captura_operando_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned VAL_W = 14,
   parameter int unsigned DIG_W = 3
);
   logic [WIDTH-1:0] key_col;
   logic [WIDTH-1:0] key_row;
   logic             key_valid;
   logic             key_ack;
   logic [VAL_W-1:0] entry_value;
   logic [DIG_W-1:0] entry_digits;
   logic [VAL_W-1:0] operand;
   logic [DIG_W-1:0] operand_digits;
   logic             operand_valid;
   logic             operand_ack;
   logic             drop_pulse;

   modport master (
      output key_col, key_row, key_valid, operand_ack,
      input  key_ack, entry_value, entry_digits, operand, operand_digits, operand_valid,
             drop_pulse
   );

   modport slave (
      input  key_col, key_row, key_valid, operand_ack,
      output key_ack, entry_value, entry_digits, operand, operand_digits, operand_valid,
             drop_pulse
   );
endinterface

// File: rtl/captura_operando_decodificador_tecla.sv
// Combinational keypad decoder: one-hot column/row (MSB = index 0) to key code.
module decodificador_tecla
   import teclado_pkg::*;
#(
   parameter int unsigned WIDTH = KP_WIDTH
) (
   input  logic [WIDTH-1:0] key_col,
   input  logic [WIDTH-1:0] key_row,
   output key_code_t        code
);
   int ci;
   int ri;

   always_comb begin
      code = KEY_NONE;
      ci   = 0;
      ri   = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (key_col[WIDTH-1-i]) ci = i;
         if (key_row[WIDTH-1-i]) ri = i;
      end
      if ($onehot(key_col) && $onehot(key_row)) begin
         if (ri < 3 && ci < 3) begin
            code = key_code_t'(4'(ri * 3 + ci + 1));
         end else if (ri == 3) begin
            case (ci)
               0:       code = KEY_STAR;
               1:       code = KEY_0;
               2:       code = KEY_HASH;
               default: code = KEY_NONE;
            endcase
         end
      end
   end
endmodule

// File: rtl/captura_operando.sv
// Builds decimal operands from debounced keys and offers them via valid/ack.
// Optional idle timeout of a partial entry: define CAPTURA_TIMEOUT_EN.
module captura_operando
   import teclado_pkg::*;
#(
   parameter int unsigned WIDTH          = KP_WIDTH,
   parameter int unsigned MAX_DIGITS     = DEFAULT_MAX_DIGITS,
   parameter int unsigned VAL_W          = 14
`ifdef CAPTURA_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
) (
   input logic               clk,
   input logic               rst_n,
   captura_operando_if.slave bus
);
   localparam int unsigned DIG_W = $clog2(MAX_DIGITS + 1);

   cap_state_t       state_q, state_d;
   logic [WIDTH-1:0] key_col_q, key_col_d, key_row_q, key_row_d;
   logic             key_ack_q, key_ack_d, drop_q, drop_d;
   logic [VAL_W-1:0] entry_value_q, entry_value_d, operand_q, operand_d;
   logic [DIG_W-1:0] entry_digits_q, entry_digits_d, operand_digits_q, operand_digits_d;
   logic             operand_valid_q, operand_valid_d;
   logic             commit;
   key_code_t        code;

`ifdef CAPTURA_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] timeout_q, timeout_d;
`endif

   decodificador_tecla #(.WIDTH(WIDTH)) u_dec (
      .key_col(key_col_q),
      .key_row(key_row_q),
      .code   (code)
   );

   always_comb begin
      state_d          = state_q;
      key_col_d        = key_col_q;
      key_row_d        = key_row_q;
      key_ack_d        = 1'b0;
      drop_d           = 1'b0;
      entry_value_d    = entry_value_q;
      entry_digits_d   = entry_digits_q;
      operand_d        = operand_q;
      operand_digits_d = operand_digits_q;
      operand_valid_d  = operand_valid_q;
      commit           = 1'b0;
`ifdef CAPTURA_TIMEOUT_EN
      timeout_d        = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.key_valid) begin
               key_col_d = bus.key_col;
               key_row_d = bus.key_row;
               key_ack_d = 1'b1;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            state_d = WAIT_LOW;
            if (code <= KEY_9) begin
               if (entry_digits_q < DIG_W'(MAX_DIGITS)) begin
                  entry_value_d  = entry_value_q * VAL_W'(10) + VAL_W'(code);
                  entry_digits_d = entry_digits_q + 1'b1;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (code == KEY_STAR) begin
               entry_value_d  = '0;
               entry_digits_d = '0;
            end else if (code == KEY_HASH && entry_digits_q != '0 &&
                         (!operand_valid_q || bus.operand_ack)) begin
               commit           = 1'b1;
               operand_d        = entry_value_q;
               operand_digits_d = entry_digits_q;
               operand_valid_d  = 1'b1;
               entry_value_d    = '0;
               entry_digits_d   = '0;
            end else begin
               drop_d = 1'b1;
            end
         end
         WAIT_LOW: begin
            if (!bus.key_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.operand_ack && !commit) operand_valid_d = 1'b0;

`ifdef CAPTURA_TIMEOUT_EN
      // Only a partial entry sitting in IDLE ages; an accepted key restarts the count.
      if (state_q == IDLE) begin
         if (bus.key_valid || entry_digits_q == '0) begin
            timeout_d = '0;
         end else if (timeout_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d      = '0;
            entry_value_d  = '0;
            entry_digits_d = '0;
            drop_d         = 1'b1;
         end else begin
            timeout_d = timeout_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         key_col_q        <= '0;
         key_row_q        <= '0;
         key_ack_q        <= 1'b0;
         drop_q           <= 1'b0;
         entry_value_q    <= '0;
         entry_digits_q   <= '0;
         operand_q        <= '0;
         operand_digits_q <= '0;
         operand_valid_q  <= 1'b0;
`ifdef CAPTURA_TIMEOUT_EN
         timeout_q        <= '0;
`endif
      end else begin
         state_q          <= state_d;
         key_col_q        <= key_col_d;
         key_row_q        <= key_row_d;
         key_ack_q        <= key_ack_d;
         drop_q           <= drop_d;
         entry_value_q    <= entry_value_d;
         entry_digits_q   <= entry_digits_d;
         operand_q        <= operand_d;
         operand_digits_q <= operand_digits_d;
         operand_valid_q  <= operand_valid_d;
`ifdef CAPTURA_TIMEOUT_EN
         timeout_q        <= timeout_d;
`endif
      end
   end

   assign bus.key_ack        = key_ack_q;
   assign bus.drop_pulse     = drop_q;
   assign bus.entry_value    = entry_value_q;
   assign bus.entry_digits   = entry_digits_q;
   assign bus.operand        = operand_q;
   assign bus.operand_digits = operand_digits_q;
   assign bus.operand_valid  = operand_valid_q;
endmodule

// File: doc/captura_operando.md
Name: captura_operando

Overview:
- Downstream consumer of the keypad reading stage.
- Takes one debounced key at a time (one-hot column/row plus valid) and acknowledges it with a one-cycle ack pulse.
- Digits 0-9 build a decimal operand; '*' clears the entry; '#' commits it.
- Committed operands are offered to the arithmetic/display logic through a valid/ack handshake.

Parameters:
- WIDTH, 4, keypad column/row count (one-hot widths).
- MAX_DIGITS, 4, maximum decimal digits per operand.
- VAL_W, 14, operand width in bits; must satisfy 2^VAL_W > 10^MAX_DIGITS-1.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before a partial entry is discarded (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_col  in  WIDTH  one-hot column of the pending key; MSB = column 0.
- key_row  in  WIDTH  one-hot row of the pending key; MSB = row 0.
- key_valid  in  1  a key is pending; held until acked.
- key_ack  out  1  one-cycle pulse consuming the pending key.
- entry_value  out  VAL_W  live binary value of the digits typed so far.
- entry_digits  out  $clog2(MAX_DIGITS+1)  digits in the live entry.
- operand  out  VAL_W  last committed operand.
- operand_digits  out  $clog2(MAX_DIGITS+1)  digit count of the committed operand.
- operand_valid  out  1  committed operand available; held until operand_ack.
- operand_ack  in  1  consumer clears operand_valid.
- drop_pulse  out  1  one-cycle pulse when a consumed key had no effect.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output and internal register 0.
- Key map (row0..row3 × col0..col2):
  - Row 0: 1 2 3. Row 1: 4 5 6. Row 2: 7 8 9. Row 3: * 0 #.
  - Column 3, non-one-hot, or all-zero inputs decode to KEY_NONE.
- FSM states IDLE, DECODE, WAIT_LOW.
  - IDLE: if key_valid=1, latch key_col/key_row, register key_ack=1, go DECODE.
  - DECODE: key_ack=0; apply the latched key; go WAIT_LOW.
  - WAIT_LOW: stay until key_valid=0, then go IDLE. This prevents double consumption while upstream drops valid.
- Latency: key_valid seen in IDLE at edge t → key_ack high during cycle t+1 → entry and operand outputs updated after edge t+1 → next key accepted no earlier than edge t+3.
- Digit d with entry_digits < MAX_DIGITS: entry_value ← entry_value*10 + d; entry_digits+1. Arithmetic is VAL_W wide, so no overflow is possible.
- Digit with entry_digits = MAX_DIGITS: entry unchanged; drop_pulse.
- Leading zeros are counted as digits: keys "0","5" give value 5, digits 2.
- '*': entry_value ← 0 and entry_digits ← 0. Always succeeds, even when the entry is already empty.
- '#', entry_digits > 0, and (operand_valid=0 or operand_ack=1 in the same cycle):
  - operand ← entry_value; operand_digits ← entry_digits; operand_valid ← 1.
  - Entry cleared.
- '#' with entry_digits=0, or with operand_valid=1 and no ack: no change; entry kept; drop_pulse.
- KEY_NONE: drop_pulse only.
- operand_ack=1 with no commit in that cycle: operand_valid ← 0. operand and operand_digits hold their values.
- drop_pulse and key_ack are never high in the same cycle.
- key_valid low in IDLE: no activity.

Optional Feature:
- Macro: CAPTURA_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle while entry_digits > 0 and the state is IDLE.
  - It resets to 0 on any key acceptance.
  - On reaching TIMEOUT_CYCLES-1, the entry clears and drop_pulse fires.
  - A committed operand is unaffected.
- Undefined: no counter exists; a partial entry persists indefinitely.

Decomposition:
- Package teclado_pkg holds:
  - typedef enum key_code_t {KEY_0..KEY_9, KEY_STAR, KEY_HASH, KEY_NONE};
  - typedef enum cap_state_t {IDLE, DECODE, WAIT_LOW};
  - constants KP_WIDTH=4 and DEFAULT_MAX_DIGITS=4.
- Sub-module decodificador_tecla: combinational key_col/key_row → key_code_t. Instantiated once on the latched key.

Test Plan:
- Reset with key_valid=1 held high → all outputs 0. After release: key_ack pulses exactly once, then FSM waits in WAIT_LOW for valid low.
- Keys 1,2,3,# (col 1000/row 1000, 0100/1000, 0010/1000, 0010/0001) → entry_value 1,12,123; then operand=123, operand_digits=3, operand_valid=1, entry cleared.
- Keys 9,9,9,9,9 with MAX_DIGITS=4 → entry_value=9999, fifth key gives drop_pulse, value unchanged; '*' → entry_value=0, digits=0.
- Commit 42 without operand_ack, then 7,# → second '#' drop_pulse, operand stays 42, entry stays 7.
  - Repeat with operand_ack asserted in the DECODE cycle of '#' → operand=7, operand_valid stays 1.
- Key col=0001 or col=1100 → key_ack then drop_pulse, no state change. '#' on empty entry → drop_pulse.
- Assert rst_n=0 in DECODE after digit 5 → immediate clear, no commit. With CAPTURA_TIMEOUT_EN and TIMEOUT_CYCLES=20: digit 3 then 20 idle cycles → entry clears and drop_pulse fires.
